// File: rtl/nl_activation_buffer_if.sv
// rtl/nl_activation_buffer_if.sv - engine and host access signals of the activation buffer
//  master: engine/host side (drives strobes, addresses, write data)
//  slave : buffer side (drives read_word, host_gnt, host_rdata, host_rvalid)
interface nl_activation_buffer_if #(
    parameter int ADDR_W = 15,
    parameter int WORD_W = 32
);
    logic                     input_channel_rd_en;
    logic [ADDR_W-1:0]        input_channel_rd_addr;
    logic signed [WORD_W-1:0] read_word;
    logic                     wr_en_output_buffer_nl;
    logic [ADDR_W-1:0]        wr_addr_nl;
    logic signed [WORD_W-1:0] output_word;
    logic                     host_req;
    logic                     host_we;
    logic [ADDR_W-1:0]        host_addr;
    logic [WORD_W-1:0]        host_wdata;
    logic                     host_gnt;
    logic [WORD_W-1:0]        host_rdata;
    logic                     host_rvalid;

    modport master (
        output input_channel_rd_en, input_channel_rd_addr,
        output wr_en_output_buffer_nl, wr_addr_nl, output_word,
        output host_req, host_we, host_addr, host_wdata,
        input  read_word, host_gnt, host_rdata, host_rvalid
    );

    modport slave (
        input  input_channel_rd_en, input_channel_rd_addr,
        input  wr_en_output_buffer_nl, wr_addr_nl, output_word,
        input  host_req, host_we, host_addr, host_wdata,
        output read_word, host_gnt, host_rdata, host_rvalid
    );
endinterface

// File: rtl/nl_activation_buffer.sv
// rtl/nl_activation_buffer.sv - activation memory serving the nonlinear engine, host access outside sessions
//  clk, reset               : clock, asynchronous active-high reset
//  enable_nonlinear_block   : session request level
//  finished_activation      : engine pulse, last write issued
//  buf_busy                 : session in progress (state != IDLE)
//  wr_count                 : engine writes accepted this session, saturating
//  oob_error                : sticky engine out-of-range flag, cleared on session entry
//  bus (slave)              : engine read/write port and host request port
module nl_activation_buffer #(
    parameter int N_DIM_ARRAY = 4,
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 15,
    parameter int DEPTH       = 32768,
    parameter int CNT_W       = 16,
    parameter int WORD_W      = N_DIM_ARRAY * DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable_nonlinear_block,
    input  logic              finished_activation,
    output logic              buf_busy,
    output logic [CNT_W-1:0]  wr_count,
    output logic              oob_error,
    nl_activation_buffer_if.slave bus
);
    localparam int              IDX_W   = $clog2(DEPTH);
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;

    state_t              state_q, state_d;
    logic [WORD_W-1:0]   read_word_q, read_word_d;
    logic [WORD_W-1:0]   host_rdata_q, host_rdata_d;
    logic                host_rvalid_q, host_rvalid_d;
    logic [CNT_W-1:0]    wr_count_q, wr_count_d;
    logic                oob_q, oob_d;

    logic [WORD_W-1:0]   mem [0:DEPTH-1];

    logic eng_act, rd_in, wr_in, host_in, eng_wr_ok, host_wr_ok, entering;

    assign eng_act    = (state_q != IDLE);
    assign rd_in      = ({1'b0, bus.input_channel_rd_addr} < DEPTH_L);
    assign wr_in      = ({1'b0, bus.wr_addr_nl} < DEPTH_L);
    assign host_in    = ({1'b0, bus.host_addr} < DEPTH_L);
    assign bus.host_gnt = bus.host_req & (state_q == IDLE) & ~reset;
    assign eng_wr_ok  = eng_act & bus.wr_en_output_buffer_nl & wr_in;
    assign host_wr_ok = bus.host_gnt & bus.host_we & host_in;
    assign entering   = (state_q == IDLE) & (state_d == ACTIVE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   if (enable_nonlinear_block) state_d = ACTIVE;
            ACTIVE: if (finished_activation)         state_d = DRAIN;
                    else if (!enable_nonlinear_block) state_d = IDLE;
            DRAIN:  if (!enable_nonlinear_block) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        read_word_d   = read_word_q;
        host_rdata_d  = host_rdata_q;
        host_rvalid_d = 1'b0;
        wr_count_d    = wr_count_q;
        oob_d         = oob_q;

        if (eng_act && bus.input_channel_rd_en) begin
            if (!rd_in)
                read_word_d = '0;
            // write-first on a same-address collision
            else if (eng_wr_ok && bus.wr_addr_nl == bus.input_channel_rd_addr)
                read_word_d = bus.output_word;
            else
                read_word_d = mem[bus.input_channel_rd_addr[IDX_W-1:0]];
        end

        if (entering) begin
            wr_count_d = '0;
            oob_d      = 1'b0;
        end else begin
            if (eng_wr_ok && wr_count_q != {CNT_W{1'b1}})
                wr_count_d = wr_count_q + CNT_W'(1);
            if (eng_act && ((bus.wr_en_output_buffer_nl && !wr_in) ||
                            (bus.input_channel_rd_en && !rd_in)))
                oob_d = 1'b1;
        end

        if (bus.host_gnt && !bus.host_we) begin
            host_rvalid_d = 1'b1;
            host_rdata_d  = host_in ? mem[bus.host_addr[IDX_W-1:0]] : '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            read_word_q   <= '0;
            host_rdata_q  <= '0;
            host_rvalid_q <= 1'b0;
            wr_count_q    <= '0;
            oob_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            read_word_q   <= read_word_d;
            host_rdata_q  <= host_rdata_d;
            host_rvalid_q <= host_rvalid_d;
            wr_count_q    <= wr_count_d;
            oob_q         <= oob_d;
        end
    end

    // Memory is not reset; gating on reset keeps a write presented in the reset cycle from landing.
    // Engine and host writes are mutually exclusive since the host is only granted in IDLE.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (eng_wr_ok)
                mem[bus.wr_addr_nl[IDX_W-1:0]] <= bus.output_word;
            else if (host_wr_ok)
                mem[bus.host_addr[IDX_W-1:0]] <= bus.host_wdata;
        end
    end

    assign bus.read_word   = read_word_q;
    assign bus.host_rdata  = host_rdata_q;
    assign bus.host_rvalid = host_rvalid_q;
    assign buf_busy        = (state_q != IDLE);
    assign wr_count        = wr_count_q;
    assign oob_error       = oob_q;
endmodule

// File: tb/tb_nl_activation_buffer.sv
// tb/tb_nl_activation_buffer.sv - self-checking bench for nl_activation_buffer
module tb_nl_activation_buffer;
    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable_nonlinear_block;
    logic        finished_activation;
    logic        buf_busy;
    logic [15:0] wr_count;
    logic        oob_error;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem_m [0:DEPTH-1];

    nl_activation_buffer_if #(.ADDR_W(15), .WORD_W(32)) bus ();

    nl_activation_buffer #(.DEPTH(DEPTH)) dut (
        .clk                    (clk),
        .reset                  (reset),
        .enable_nonlinear_block (enable_nonlinear_block),
        .finished_activation    (finished_activation),
        .buf_busy               (buf_busy),
        .wr_count               (wr_count),
        .oob_error              (oob_error),
        .bus                    (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [14:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
    } host_vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic host_write(input logic [14:0] a, input logic [31:0] d);
        int n = 0;
        bus.host_req = 1'b1; bus.host_we = 1'b1; bus.host_addr = a; bus.host_wdata = d;
        #1;
        while (!bus.host_gnt && n < 20) begin tick(); n++; end
        if (n == 20) chk("host_write_gnt_timeout", 32'd0, 32'd1);
        tick();
        bus.host_req = 1'b0; bus.host_we = 1'b0;
        if (a < DEPTH) mem_m[a] = d;
    endtask

    task automatic host_read(input string name, input logic [14:0] a, input logic [31:0] exp);
        int n = 0;
        bus.host_req = 1'b1; bus.host_we = 1'b0; bus.host_addr = a;
        #1;
        while (!bus.host_gnt && n < 20) begin tick(); n++; end
        if (n == 20) chk({name, "_gnt_timeout"}, 32'd0, 32'd1);
        tick();
        bus.host_req = 1'b0;
        chk({name, "_rvalid"}, {31'd0, bus.host_rvalid}, 32'd1);
        chk({name, "_rdata"}, bus.host_rdata, exp);
        tick();
        chk({name, "_rvalid_pulse"}, {31'd0, bus.host_rvalid}, 32'd0);
        chk({name, "_rdata_hold"}, bus.host_rdata, exp);
    endtask

    task automatic idle_engine();
        bus.input_channel_rd_en = 1'b0; bus.wr_en_output_buffer_nl = 1'b0;
        finished_activation = 1'b0;
    endtask

    host_vec_t vecs [6];

    initial begin
        logic [31:0] rw_m;
        int          cnt_m;
        logic        oob_m;
        int          n;

        vecs[0] = '{15'd0,     32'h0000_0001, 32'h0000_0001};
        vecs[1] = '{15'd7,     32'h8000_0000, 32'h8000_0000};
        vecs[2] = '{15'd1023,  32'hCAFE_F00D, 32'hCAFE_F00D};
        vecs[3] = '{15'd1024,  32'h1234_5678, 32'h0000_0000};
        vecs[4] = '{15'd32767, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[5] = '{15'd512,   32'h5A5A_0F0F, 32'h5A5A_0F0F};

        reset = 1'b1; enable_nonlinear_block = 1'b0;
        bus.host_req = 1'b0; bus.host_we = 1'b0; bus.host_addr = '0; bus.host_wdata = '0;
        bus.input_channel_rd_addr = '0; bus.wr_addr_nl = '0; bus.output_word = '0;
        idle_engine();
        tick(); tick();
        chk("reset_read_word", bus.read_word, 32'd0);
        chk("reset_host_rdata", bus.host_rdata, 32'd0);
        chk("reset_rvalid", {31'd0, bus.host_rvalid}, 32'd0);
        chk("reset_wr_count", {16'd0, wr_count}, 32'd0);
        chk("reset_oob", {31'd0, oob_error}, 32'd0);
        chk("reset_busy", {31'd0, buf_busy}, 32'd0);
        chk("reset_gnt_blocked", {31'd0, bus.host_gnt}, 32'd0);
        reset = 1'b0;
        tick();

        // host table: write then read back, OOB writes drop and read 0
        foreach (vecs[i]) begin
            host_write(vecs[i].addr, vecs[i].wdata);
            host_read($sformatf("host_vec%0d", i), vecs[i].addr, vecs[i].exp_rdata);
        end
        chk("host_oob_no_flag", {31'd0, oob_error}, 32'd0);

        // 1: host load, engine read latency and hold
        host_write(15'd5, 32'h1122_3344);
        enable_nonlinear_block = 1'b1;
        tick();
        chk("t1_busy", {31'd0, buf_busy}, 32'd1);
        bus.input_channel_rd_en = 1'b1; bus.input_channel_rd_addr = 15'd5;
        tick();
        bus.input_channel_rd_en = 1'b0;
        chk("t1_read", bus.read_word, 32'h1122_3344);
        tick();
        chk("t1_hold", bus.read_word, 32'h1122_3344);

        // 2: same-address read/write is write-first
        bus.input_channel_rd_en = 1'b1; bus.input_channel_rd_addr = 15'd9;
        bus.wr_en_output_buffer_nl = 1'b1; bus.wr_addr_nl = 15'd9; bus.output_word = 32'hA5A5_A5A5;
        tick();
        idle_engine();
        chk("t2_write_first", bus.read_word, 32'hA5A5_A5A5);
        chk("t2_wr_count", {16'd0, wr_count}, 32'd1);

        // 3: out-of-range engine access
        bus.input_channel_rd_en = 1'b1; bus.input_channel_rd_addr = 15'd2000;
        bus.wr_en_output_buffer_nl = 1'b1; bus.wr_addr_nl = 15'd1024; bus.output_word = 32'h7777_7777;
        tick();
        idle_engine();
        chk("t3_read_zero", bus.read_word, 32'd0);
        chk("t3_oob", {31'd0, oob_error}, 32'd1);
        chk("t3_count", {16'd0, wr_count}, 32'd1);
        enable_nonlinear_block = 1'b0;
        tick();
        chk("t3_idle", {31'd0, buf_busy}, 32'd0);
        chk("t3_oob_sticky", {31'd0, oob_error}, 32'd1);
        bus.input_channel_rd_en = 1'b1; bus.input_channel_rd_addr = 15'd5;
        tick();
        bus.input_channel_rd_en = 1'b0;
        chk("t3_idle_read_ignored", bus.read_word, 32'd0);
        enable_nonlinear_block = 1'b1;
        tick();
        chk("t3_reentry_oob_clear", {31'd0, oob_error}, 32'd0);
        chk("t3_reentry_count_clear", {16'd0, wr_count}, 32'd0);

        // 4: 16 writes + finished with 17th -> DRAIN
        for (int i = 0; i < 17; i++) begin
            bus.wr_en_output_buffer_nl = 1'b1; bus.wr_addr_nl = 15'(100 + i);
            bus.output_word = 32'hBEEF_0000 + i;
            finished_activation = (i == 16);
            tick();
        end
        idle_engine();
        chk("t4_count", {16'd0, wr_count}, 32'd17);
        chk("t4_drain_busy", {31'd0, buf_busy}, 32'd1);
        tick();
        chk("t4_drain_stays", {31'd0, buf_busy}, 32'd1);
        enable_nonlinear_block = 1'b0;
        tick();
        chk("t4_idle", {31'd0, buf_busy}, 32'd0);
        host_read("t4_last", 15'd116, 32'hBEEF_0010);
        host_read("t2_back", 15'd9, 32'hA5A5_A5A5);

        // 5: host blocked during session
        enable_nonlinear_block = 1'b1;
        tick();
        bus.host_req = 1'b1; bus.host_we = 1'b0; bus.host_addr = 15'd5;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t5_gnt_blocked", {31'd0, bus.host_gnt}, 32'd0);
            tick();
        end
        chk("t5_no_rvalid", {31'd0, bus.host_rvalid}, 32'd0);
        enable_nonlinear_block = 1'b0;
        tick();
        n = 0;
        while (!bus.host_gnt && n < 10) begin tick(); n++; end
        chk("t5_gnt_first_idle", n, 0);
        tick();
        bus.host_req = 1'b0;
        chk("t5_rvalid", {31'd0, bus.host_rvalid}, 32'd1);
        chk("t5_rdata", bus.host_rdata, 32'h1122_3344);

        // 6: reset mid-session during a write
        host_write(15'd200, 32'hDEAD_BEEF);
        enable_nonlinear_block = 1'b1;
        tick();
        bus.wr_en_output_buffer_nl = 1'b1; bus.wr_addr_nl = 15'd201; bus.output_word = 32'h1;
        bus.input_channel_rd_en = 1'b1; bus.input_channel_rd_addr = 15'd5;
        tick();
        bus.wr_addr_nl = 15'd200; bus.output_word = 32'h0BAD_F00D;
        reset = 1'b1;
        tick();
        idle_engine();
        enable_nonlinear_block = 1'b0;
        chk("t6_busy", {31'd0, buf_busy}, 32'd0);
        chk("t6_read_word", bus.read_word, 32'd0);
        chk("t6_count", {16'd0, wr_count}, 32'd0);
        reset = 1'b0;
        tick();
        host_read("t6_old_data", 15'd200, 32'hDEAD_BEEF);
        host_read("t6_prior_write", 15'd201, 32'h1);

        // randomized session against a word-array model
        for (int a = 0; a < 64; a++) host_write(15'(a), $urandom);
        enable_nonlinear_block = 1'b1;
        tick();
        rw_m = 32'd0; cnt_m = 0; oob_m = 1'b0;
        for (int c = 0; c < 300; c++) begin
            logic        rd, wr;
            logic [14:0] ra, wa;
            logic [31:0] d;
            rd = 1'($urandom % 2);
            wr = 1'($urandom % 2);
            ra = ($urandom % 8 == 0) ? 15'(1024 + $urandom % 3000) : 15'($urandom % 64);
            wa = ($urandom % 8 == 0) ? 15'(1024 + $urandom % 3000) : 15'($urandom % 64);
            d  = $urandom;
            bus.input_channel_rd_en = rd; bus.input_channel_rd_addr = ra;
            bus.wr_en_output_buffer_nl = wr; bus.wr_addr_nl = wa; bus.output_word = d;
            if (rd) rw_m = (ra >= DEPTH) ? 32'd0 : (wr && wa == ra) ? d : mem_m[ra];
            if (wr && wa < DEPTH) begin mem_m[wa] = d; cnt_m++; end
            if ((wr && wa >= DEPTH) || (rd && ra >= DEPTH)) oob_m = 1'b1;
            tick();
            chk("rnd_read_word", bus.read_word, rw_m);
            chk("rnd_wr_count", {16'd0, wr_count}, 32'(cnt_m));
            chk("rnd_oob", {31'd0, oob_error}, {31'd0, oob_m});
        end
        idle_engine();
        enable_nonlinear_block = 1'b0;
        tick();
        for (int a = 0; a < 64; a += 7) host_read($sformatf("rnd_back%0d", a), 15'(a), mem_m[a]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
